mult_rr_arbiter: RTL
====================

MULT_RR_ARBITER -- requirements
Module: mult_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter MUL_LATENCY, default 5, cycles from operands on mul_a/mul_b to matching mul_product.
REQ-004 SHALL derive ID_W = max(1, clog2(NUM_REQ)).
REQ-005 SHALL have clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have enable  input  1  permits new grants when high.
REQ-008 SHALL have req_valid  input  NUM_REQ  per-requester request.
REQ-009 SHALL have req_a, req_b  input  NUM_REQ*WIDTH each  flattened operands; requester i in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have req_ready  output  NUM_REQ  one-hot grant (or zero).
REQ-011 SHALL have mul_a, mul_b  output  WIDTH each  registered operands to the shared multiplier.
REQ-012 SHALL have mul_product  input  2*WIDTH  multiplier result.
REQ-013 SHALL have rsp_valid  output  1; rsp_id  output  ID_W; rsp_product  output  2*WIDTH  registered response.
REQ-014 SHALL have idle  output  1  high when nothing in flight.

Function
REQ-015 Handshake: request i accepted in cycle t iff req_valid[i] && req_ready[i] at posedge ending t.
REQ-016 req_ready SHALL be combinational from req_valid, enable, rr pointer; at most one bit set; all zero when enable low or reset high.
REQ-017 Arbitration round-robin: search starts at pointer p, ascending index mod NUM_REQ; first valid wins.
REQ-018 After a grant to i, p <= (i+1) mod NUM_REQ; p unchanged on cycles without grant.
REQ-019 Max one acceptance per cycle; back-to-back acceptances every cycle allowed (full throughput).
REQ-020 Accepted operands SHALL appear on mul_a/mul_b in cycle t+1; mul_a/mul_b hold last values when no issue.
REQ-021 Tag pipeline: MUL_LATENCY+1-deep shift register of {valid, id}; entry written on each issue, valid=0 bubble otherwise.
REQ-022 rsp_valid/rsp_id/rsp_product SHALL register the tag tail and mul_product; accepted in cycle t -> rsp_valid=1 in cycle t+MUL_LATENCY+2, exactly one cycle wide.
REQ-023 rsp_product SHALL equal unsigned req_a*req_b of the accepted transaction, full 2*WIDTH bits, no truncation.
REQ-024 No response backpressure; responses emitted in issue order, never dropped or duplicated.
REQ-025 rsp_product/rsp_id hold last value when rsp_valid=0.
REQ-026 In-flight counter (width clog2(MUL_LATENCY+3)): +1 on accept, -1 on rsp_valid, unchanged on both simultaneously; idle = (count==0).
REQ-027 enable deasserted mid-stream: in-flight transactions SHALL complete normally; idle rises after last rsp_valid.
REQ-028 Requester may drop req_valid without handshake; no ordering obligation otherwise.
REQ-029 Only one requester valid: SHALL be granted every cycle regardless of p.

Reset
REQ-030 On reset: req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_product=0, p=0, count=0, idle=1, all tag valids cleared.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; no rsp_valid for them afterward; multiplier reset by the same reset.
REQ-032 First cycle after reset release SHALL be able to grant.

Verification
REQ-033 Reset then req_valid=4'b1111, enable=1, req i operands a=i+1, b=3 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id 0,1,2,3 at t+7..t+10 with products 3,6,9,12.
REQ-034 Single requester 2 valid continuously, a=255,b=255 -> ready[2]=1 every cycle; rsp_product=16'hFE01 every cycle from t+7; idle=0.
REQ-035 All valid, enable dropped after 3 grants -> req_ready=0; exactly 3 rsp_valid pulses; idle=1 the cycle after the third.
REQ-036 Pointer check: grant to 3 with NUM_REQ=4, then req_valid=4'b0101 -> requester 0 granted before 2.
REQ-037 Reset asserted 2 cycles after 3 acceptances -> no rsp_valid until new accepts; count=0, p=0.
REQ-038 Random valid/operands 10k cycles, scoreboard per id -> every accept matched by one in-order rsp with exact product.

Source files
------------

// File: rtl/mult_rr_arbiter.sv
// Round-robin front end for a shared pipelined multiplier: picks one requester
// per cycle, issues its operands, tracks ids alongside the multiplier latency
// and returns the product tagged with the requester id.
module mult_rr_arbiter #(
  parameter  int WIDTH       = 8,
  parameter  int NUM_REQ     = 4,
  parameter  int MUL_LATENCY = 5,
  localparam int ID_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W       = $clog2(MUL_LATENCY + 3)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_product,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [2*WIDTH-1:0]         rsp_product,
  output logic                       idle
);

  // Requester index (base + off) wrapped into 0..NUM_REQ-1.
  function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  logic [ID_W-1:0]  rr_ptr;
  logic             accept;
  logic [ID_W-1:0]  grant_id;
  logic [CNT_W-1:0] inflight_cnt;

  logic             tag_vld_p [0:MUL_LATENCY];
  logic [ID_W-1:0]  tag_id_p  [0:MUL_LATENCY];

  // Round-robin search from rr_ptr upward; the first valid requester wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    req_ready = '0;
    accept    = 1'b0;
    grant_id  = '0;
    idx       = '0;
    if (enable && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = wrap_idx(int'(rr_ptr), k);
        if (!accept && req_valid[idx]) begin
          accept   = 1'b1;
          grant_id = idx;
        end
      end
      if (accept) req_ready[grant_id] = 1'b1;
    end
  end

  // Pointer moves just past the winner, and only on a grant.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else if (accept) rr_ptr <= wrap_idx(int'(grant_id), 1);
  end

  // ---- stage p0: issue the granted operands to the multiplier ----
  // Operand registers hold their last value between issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      mul_a <= req_a[int'(grant_id)*WIDTH +: WIDTH];
      mul_b <= req_b[int'(grant_id)*WIDTH +: WIDTH];
    end
  end

  // ---- stages p0..pL: tag travels beside the multiplier pipeline ----
  // Valid bits shift every cycle; a bubble enters when nothing is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= MUL_LATENCY; i++) tag_vld_p[i] <= 1'b0;
    end else begin
      tag_vld_p[0] <= accept;
      for (int i = 1; i <= MUL_LATENCY; i++) tag_vld_p[i] <= tag_vld_p[i-1];
    end
  end

  // Ids shift unconditionally; they only matter where the valid bit is set.
  always_ff @(posedge clk) begin
    tag_id_p[0] <= grant_id;
    for (int i = 1; i <= MUL_LATENCY; i++) tag_id_p[i] <= tag_id_p[i-1];
  end

  // ---- response stage: tag tail lines up with mul_product ----
  // Response id/product hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      rsp_valid <= tag_vld_p[MUL_LATENCY];
      if (tag_vld_p[MUL_LATENCY]) begin
        rsp_id      <= tag_id_p[MUL_LATENCY];
        rsp_product <= mul_product;
      end
    end
  end

  // In-flight count: accepted but not yet answered.
  always_ff @(posedge clk) begin
    if (reset) inflight_cnt <= '0;
    else begin
      case ({accept, rsp_valid})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  assign idle = (inflight_cnt == '0);

endmodule
